inst_fetch_axi: RTL

//  Instruction-fetch stage: owns the PC and fetches 32-bit words over an AXI-Lite read master.

---
 rtl/inst_fetch_axi.sv | 139 +++++++++++++
 1 files changed

// File: rtl/inst_fetch_axi.sv
// Instruction-fetch stage: owns the PC and fetches one 32-bit word at a time over an
// AXI-Lite read master, handing {pc, inst} to IF/ID through a valid/ready register.
module inst_fetch_axi #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_err
);

  // IDLE: post-reset | AR: address phase | R: data phase | HOLD: output reg full, no fetch
  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_HOLD} state_t;

  state_t            r_state, w_state_n;
  logic [ADDR_W-1:0] r_pc, w_pc_n;
  logic [ADDR_W-1:0] r_araddr;
  logic              r_kill, w_kill_n;
  logic              r_if_valid, w_if_valid_n;
  logic [ADDR_W-1:0] r_if_pc, w_if_pc_n;
  logic [DATA_W-1:0] r_if_inst, w_if_inst_n;
  logic              r_if_err, w_if_err_n;
  logic              w_xfer;
  logic              w_rready;
  logic              w_rdone;
  logic [ADDR_W-1:0] w_redir_pc;

  assign w_xfer     = r_if_valid & if_ready;
  assign w_redir_pc = redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
  // Data is only accepted when it cannot overwrite an unconsumed output word.
  assign w_rready   = (r_state == S_R) & (r_kill | redirect_valid | ~r_if_valid | if_ready);
  assign w_rdone    = m_rvalid & w_rready;

  always_comb begin
    w_state_n    = r_state;
    w_pc_n       = r_pc;
    w_kill_n     = r_kill;
    w_if_valid_n = r_if_valid & ~w_xfer;
    w_if_pc_n    = r_if_pc;
    w_if_inst_n  = r_if_inst;
    w_if_err_n   = r_if_err;

    case (r_state)
      S_IDLE: w_state_n = S_AR;
      S_AR: begin
        if (m_arready) w_state_n = S_R;
      end
      S_R: begin
        if (w_rdone) begin
          if (r_kill) begin
            w_kill_n  = 1'b0;
            w_state_n = S_AR;
          end else begin
            w_if_valid_n = 1'b1;
            w_if_pc_n    = r_pc;
            w_if_inst_n  = (m_rresp == 2'b00) ? m_rdata : '0;
            w_if_err_n   = (m_rresp != 2'b00);
            w_pc_n       = r_pc + ADDR_W'(4);
            w_state_n    = if_ready ? S_AR : S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_xfer) w_state_n = S_AR;
      end
      default: w_state_n = S_IDLE;
    endcase

    if (redirect_valid) begin
      w_pc_n       = w_redir_pc;
      w_if_valid_n = 1'b0;
      w_if_err_n   = 1'b0;
      case (r_state)
        S_IDLE, S_HOLD: begin
          w_state_n = S_AR;
          w_kill_n  = 1'b0;
        end
        S_AR: w_kill_n = 1'b1;
        S_R: begin
          if (w_rdone) begin
            w_state_n = S_AR;
            w_kill_n  = 1'b0;
          end else begin
            w_kill_n  = 1'b1;
          end
        end
        default: w_kill_n = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_araddr   <= RESET_PC;
      r_kill     <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_inst  <= '0;
      r_if_err   <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      // A presented address stays put until accepted, even across a redirect.
      r_araddr   <= (r_state == S_AR) ? r_araddr : w_pc_n;
      r_kill     <= w_kill_n;
      r_if_valid <= w_if_valid_n;
      r_if_pc    <= w_if_pc_n;
      r_if_inst  <= w_if_inst_n;
      r_if_err   <= w_if_err_n;
    end
  end

  assign m_araddr  = r_araddr;
  assign m_arprot  = 3'b100;
  assign m_arvalid = (r_state == S_AR);
  assign m_rready  = w_rready;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_inst   = r_if_inst;
  assign if_err    = r_if_err;

endmodule
